// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC, one-outstanding imem fetch FSM and IF/ID register.
// Macro FETCH_BUBBLE_HOLD_EN: a bubble clears only if_id_valid and holds if_id_pc/if_id_instr.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_write,
   input  logic        if_id_write,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_id_valid,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_instr
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] hb_pc;
   logic [31:0] hb_instr;
   logic        kill;

   logic        accept;
   logic        bubble;
   logic        ld_fetch;
   logic        ld_hold;
   logic [31:0] target;
   logic [31:0] pc_inc;

   assign accept = pc_write & if_id_write;
   assign target = redirect_pc & 32'hFFFF_FFFC;
   assign pc_inc = pc + 32'd4;

   // IF/ID update selection; a redirect forces a bubble even under stall
   always_comb begin
      bubble   = 1'b0;
      ld_fetch = 1'b0;
      ld_hold  = 1'b0;
      if (redirect_valid) begin
         bubble = 1'b1;
      end else begin
         case (state)
            WAIT: begin
               if (!imem_rvalid || kill) bubble   = if_id_write;
               else                      ld_fetch = accept;
            end
            HOLD:    ld_hold = accept;
            default: ;
         endcase
      end
   end

   // Fetch FSM; imem_req is registered, so it is raised on every entry into REQ
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         kill      <= 1'b0;
         hb_pc     <= '0;
         hb_instr  <= NOP_INSTR;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
      end else begin
         imem_req <= 1'b0;
         if (redirect_valid) begin
            pc <= target;
            if (state == REQ || (state == WAIT && !imem_rvalid)) begin
               kill  <= 1'b1;
               state <= WAIT;
            end else begin
               kill      <= 1'b0;
               state     <= REQ;
               imem_req  <= 1'b1;
               imem_addr <= target;
            end
         end else begin
            case (state)
               IDLE: begin
                  state     <= REQ;
                  imem_req  <= 1'b1;
                  imem_addr <= pc;
               end
               REQ: state <= WAIT;
               WAIT: begin
                  if (imem_rvalid) begin
                     if (kill) begin
                        kill      <= 1'b0;
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                     end else if (accept) begin
                        pc        <= pc_inc;
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= pc_inc;
                     end else begin
                        hb_pc    <= pc;
                        hb_instr <= imem_rdata;
                        state    <= HOLD;
                     end
                  end
               end
               HOLD: begin
                  if (accept) begin
                     pc        <= pc_inc;
                     state     <= REQ;
                     imem_req  <= 1'b1;
                     imem_addr <= pc_inc;
                  end
               end
            endcase
         end
      end
   end

   // IF/ID pipeline register
   always_ff @(posedge clk) begin
      if (rst) begin
         if_id_valid <= 1'b0;
         if_id_pc    <= '0;
         if_id_instr <= NOP_INSTR;
      end else if (bubble) begin
         if_id_valid <= 1'b0;
`ifdef FETCH_BUBBLE_HOLD_EN
         if_id_pc    <= if_id_pc;
         if_id_instr <= if_id_instr;
`else
         if_id_pc    <= '0;
         if_id_instr <= NOP_INSTR;
`endif
      end else if (ld_fetch) begin
         if_id_valid <= 1'b1;
         if_id_pc    <= pc;
         if_id_instr <= imem_rdata;
      end else if (ld_hold) begin
         if_id_valid <= 1'b1;
         if_id_pc    <= hb_pc;
         if_id_instr <= hb_instr;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed stalls/redirects, memory returns addr^32'hA5A5_0000.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_write;
   logic        if_id_write;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          mem_lat  = 1;

   logic [63:0] req_q[$];
   logic [95:0] ifid_q[$];

   fetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .pc_write       (pc_write),
      .if_id_write    (if_id_write),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .if_id_valid    (if_id_valid),
      .if_id_pc       (if_id_pc),
      .if_id_instr    (if_id_instr)
   );

   always #5 clk = ~clk;

   // cycle 1 is the first cycle with rst low
   always @(posedge clk) begin
      if (rst) cyc <= 1;
      else     cyc <= cyc + 1;
   end

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // memory model: responds mem_lat cycles after a request, settles after the stimulus
   logic        m_pend = 1'b0;
   int          m_cd   = 0;
   logic [31:0] m_addr = '0;
   initial begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
   end
   always begin
      @(negedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (m_pend) begin
         m_cd--;
         if (m_cd == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = m_addr ^ 32'hA5A5_0000;
            m_pend      = 1'b0;
         end
      end
      if (!rst && imem_req === 1'b1) begin
         m_pend = 1'b1;
         m_cd   = mem_lat;
         m_addr = imem_addr;
      end
   end

   // monitor: pops the scoreboard on every request and on every newly loaded IF/ID entry
   logic        prev_v     = 1'b0;
   logic [31:0] prev_pc    = '0;
   logic [31:0] prev_instr = '0;
   always @(negedge clk) begin
      if (imem_req === 1'b1) begin
         if (req_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL req_unexpected actual addr=%h at cycle %0d required no request", imem_addr, cyc);
         end else begin
            chk("imem_req", {32'd0, 32'(cyc), imem_addr}, {32'd0, req_q.pop_front()});
         end
      end
      if (if_id_valid === 1'b1 &&
          (prev_v !== 1'b1 || if_id_pc !== prev_pc || if_id_instr !== prev_instr)) begin
         if (ifid_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL ifid_unexpected actual pc=%h instr=%h at cycle %0d required none",
                     if_id_pc, if_id_instr, cyc);
         end else begin
            chk("if_id", {32'(cyc), if_id_pc, if_id_instr}, ifid_q.pop_front());
         end
      end
      prev_v     = if_id_valid;
      prev_pc    = if_id_pc;
      prev_instr = if_id_instr;
   end

   task automatic push_req(input int c, input logic [31:0] a);
      req_q.push_back({32'(c), a});
   endtask

   task automatic push_ifid(input int c, input logic [31:0] p);
      ifid_q.push_back({32'(c), p, p ^ 32'hA5A5_0000});
   endtask

   task automatic go(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic stall(input logic s);
      pc_write    = ~s;
      if_id_write = ~s;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      chk("rst_req",   {95'd0, imem_req},    96'd0);
      chk("rst_addr",  {64'd0, imem_addr},   96'd0);
      chk("rst_ifid",  {32'(if_id_valid), if_id_pc, if_id_instr}, {32'd0, 32'd0, 32'h0000_0013});
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic chk_frozen(input logic [31:0] p, input logic [31:0] a);
      chk("stall_ifid", {32'(if_id_valid), if_id_pc, if_id_instr}, {32'd1, p, p ^ 32'hA5A5_0000});
      chk("stall_addr", {64'd0, imem_addr}, {64'd0, a});
   endtask

   task automatic chk_bubble(input logic [31:0] old_pc);
      chk("bubble_valid", {95'd0, if_id_valid}, 96'd0);
`ifdef FETCH_BUBBLE_HOLD_EN
      chk("bubble_body", {32'd0, if_id_pc, if_id_instr}, {32'd0, old_pc, old_pc ^ 32'hA5A5_0000});
`else
      chk("bubble_body", {32'd0, if_id_pc, if_id_instr}, {32'd0, 32'd0, 32'h0000_0013});
      if (old_pc == 32'hFFFF_FFFF) $display("unused");
`endif
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      stall(1'b0);

      push_req(2, 32'h0);   push_req(4, 32'h4);   push_req(6, 32'h8);   push_req(8, 32'hC);
      push_req(13, 32'h10); push_req(15, 32'h14); push_req(19, 32'h100); push_req(23, 32'h104);
      push_req(27, 32'h200); push_req(29, 32'h204); push_req(31, 32'hFFFF_FFFC);
      push_req(33, 32'h0);  push_req(35, 32'h4);  push_req(38, 32'h300); push_req(40, 32'h304);
      push_req(2, 32'h0);   push_req(4, 32'h4);

      push_ifid(4, 32'h0);   push_ifid(6, 32'h4);    push_ifid(8, 32'h8);   push_ifid(13, 32'hC);
      push_ifid(15, 32'h10); push_ifid(23, 32'h100); push_ifid(29, 32'h200);
      push_ifid(33, 32'hFFFF_FFFC); push_ifid(35, 32'h0); push_ifid(40, 32'h300);
      push_ifid(4, 32'h0);

      do_reset();

      // load-use stall while the response for 0xC arrives
      go(9);  stall(1'b1);
      go(10); chk_frozen(32'h8, 32'hC);
      go(11); chk_frozen(32'h8, 32'hC);
      go(12); chk_frozen(32'h8, 32'hC); stall(1'b0);

      // redirect during WAIT with latency 3
      go(15); mem_lat = 3;
      go(16); redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
      go(17); redirect_valid = 1'b0; chk_bubble(32'h10);

      // redirect and rvalid together under stall
      go(24); stall(1'b1);
      go(25); chk_frozen(32'h100, 32'h104);
      go(26); chk_frozen(32'h100, 32'h104);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
      go(27); redirect_valid = 1'b0; stall(1'b0); mem_lat = 1; chk_bubble(32'h100);

      // redirect from REQ to the top word, then wrap
      go(29); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      go(30); redirect_valid = 1'b0;
      chk("redir_req_bubble", {95'd0, if_id_valid}, 96'd0);

      // redirect from HOLD while stalled
      go(36); stall(1'b1);
      go(37); chk_frozen(32'h0, 32'h4);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
      go(38); redirect_valid = 1'b0; stall(1'b0);
      chk("hold_redir_bubble", {95'd0, if_id_valid}, 96'd0);

      // reset while a response is in flight
      go(41); do_reset();
      go(5);  stall(1'b1);
      go(9);
      chk("req_q_drained",  {64'd0, 32'(req_q.size())},  96'd0);
      chk("ifid_q_drained", {64'd0, 32'(ifid_q.size())}, 96'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

- Instruction-fetch front end of the 5-stage pipeline.
- Owns the PC and the IF/ID pipeline register, and issues one-outstanding-request fetches to instruction memory.
- Consumes the load-use stall controls (`pc_write`, `if_id_write`) and the EX-stage branch/jump redirect.
- Produces the ID-stage instruction stream, inserting bubbles on flush or fetch wait.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, default 32'h0000_0013: bubble encoding (`addi x0,x0,0`).

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pc_write` in 1: 1 allows the PC to advance (from hazard unit).
- `if_id_write` in 1: 1 allows the IF/ID register to update (from hazard unit).
- `redirect_valid` in 1: taken branch/jump resolved in EX.
- `redirect_pc` in 32: target; bits [1:0] are ignored and forced to 0.
- `imem_req` out 1: one-cycle request pulse.
- `imem_addr` out 32: word-aligned fetch address, valid while `imem_req`=1.
- `imem_rvalid` in 1: response strobe, at least 1 cycle after the request.
- `imem_rdata` in 32: instruction, valid with `imem_rvalid`.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `if_id_pc` out 32: PC of the IF/ID instruction.
- `if_id_instr` out 32: IF/ID instruction.

## Operation
- `accept` = `pc_write` & `if_id_write`.
- Internal state: `pc`, `kill` flag, hold buffer `{hb_pc, hb_instr}`, and FSM state.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE (entered only from reset): always goes to REQ next cycle.
- REQ:
  - Drives `imem_req`=1 and `imem_addr`=`pc`.
  - Always goes to WAIT next cycle.
- WAIT, no `imem_rvalid`:
  - Stay in WAIT.
  - If `if_id_write`=1, IF/ID becomes a bubble.
- WAIT, `imem_rvalid` with `kill`=1:
  - Discard the data and clear `kill`.
  - Go to REQ.
  - If `if_id_write`=1, IF/ID becomes a bubble.
- WAIT, `imem_rvalid`, `kill`=0, `accept`=1:
  - IF/ID ← {`pc`, `imem_rdata`}, valid=1.
  - `pc` ← `pc`+4.
  - Go to REQ.
- WAIT, `imem_rvalid`, `kill`=0, `accept`=0:
  - Hold buffer ← {`pc`, `imem_rdata`}.
  - IF/ID is unchanged.
  - Go to HOLD.
- HOLD, `accept`=1:
  - IF/ID ← hold buffer, valid=1.
  - `pc` ← `pc`+4.
  - Go to REQ.
- HOLD, `accept`=0: all state is unchanged.
- Bubble: `if_id_valid`←0, with contents set per Configuration.
- `if_id_write`=0 without redirect: IF/ID holds exactly, including `if_id_valid`.
- `redirect_valid`=1 has priority over stall and all FSM actions:
  - `pc` ← {`redirect_pc`[31:2], 2'b00}.
  - IF/ID becomes a bubble, regardless of `if_id_write`.
  - The hold buffer is discarded.
  - From REQ (the request is already issued): set `kill`, go to WAIT.
  - From WAIT without `imem_rvalid`: set `kill`, stay in WAIT.
  - From WAIT with `imem_rvalid` the same cycle: drop the response, go to REQ.
  - From HOLD or IDLE: go to REQ.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, state=IDLE, `kill`=0.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `if_id_valid`=0, `if_id_pc`=0, `if_id_instr`=`NOP_INSTR`.
- Reset mid-operation:
  - Any in-flight response is ignored while `rst`=1.
  - After reset, the first `imem_req` is on the 2nd cycle after `rst` deasserts.
- Latency:
  - Instruction visible in IF/ID the cycle after `imem_rvalid`, when `accept`=1.
  - With response latency L cycles, steady-state throughput is one instruction per L+1 cycles.
- Redirect to first request:
  - From HOLD/IDLE: `imem_req` for the target 1 cycle after `redirect_valid`.
  - From REQ/WAIT: `imem_req` 1 cycle after the killed response returns.
- `imem_addr` holds its last value when `imem_req`=0.
- Outputs are registered only; no combinational path from inputs to outputs.

## Configuration
- Macro: `FETCH_BUBBLE_HOLD_EN`.
- Defined (low-power): a bubble clears only `if_id_valid`; `if_id_pc` and `if_id_instr` keep their previous values, so there is no datapath toggling.
- Undefined: a bubble also loads `if_id_instr`←`NOP_INSTR` and `if_id_pc`←0.

## Test plan
- Reset then free-run:
  - Memory L=1 returning `instr`=addr^32'hA5A5_0000.
  - Required: `imem_req` at cycles 2,4,6 with addr 0,4,8.
  - Required: IF/ID valid with pc 0,4,8 at cycles 4,6,8.
- Load-use stall:
  - `pc_write`=`if_id_write`=0 for 3 cycles while a response arrives.
  - Required: IF/ID frozen, FSM in HOLD, no `imem_req`.
  - Required: the buffered instruction enters IF/ID the cycle after the stall releases.
- Redirect during WAIT:
  - L=3, `redirect_valid` with `redirect_pc`=32'h0000_0103 one cycle after the request.
  - Required: the old response is dropped and `if_id_valid`=0.
  - Required: the next `imem_addr`=32'h0000_0100.
- Redirect and `imem_rvalid` in the same cycle, with stall active:
  - Required: the response is discarded and the bubble is inserted despite `if_id_write`=0.
  - Required: `imem_req` for the target on the next cycle.
- Wrap:
  - Redirect to 32'hFFFF_FFFC, then accept.
  - Required: the next `imem_addr`=0.
- Bubble contents, run with and without `FETCH_BUBBLE_HOLD_EN`:
  - Required with the macro: `if_id_instr` is unchanged on a bubble.
  - Required without the macro: `if_id_instr`=32'h0000_0013 on a bubble.
